// File: rtl/bp_io_link_arbiter_pkg.sv
// Shared constants and width helpers for the I/O link arbiter.
package bp_io_link_arbiter_pkg;

  localparam int unsigned BP_IO_MSG_WIDTH = 16;

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_io_link_rr_lock_arb.sv
// Round-robin arbiter whose grant locks once offered until the link consumes it.
//   state    | meaning
//   unlocked | grant follows round-robin search from r_ptr
//   locked   | grant pinned to r_lock_id until yumi
module bp_io_link_rr_lock_arb
  import bp_io_link_arbiter_pkg::*;
#(
  parameter int unsigned num_req_p   = 3,
  parameter int unsigned tag_width_p = safe_clog2(num_req_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [num_req_p-1:0]   reqs_i,
  input  logic                   en_i,
  input  logic                   yumi_i,
  output logic [tag_width_p-1:0] grant_id_o,
  output logic                   grant_v_o
);

  logic                   r_lock_v, w_lock_v_n;
  logic [tag_width_p-1:0] r_lock_id, w_lock_id_n;
  logic [tag_width_p-1:0] r_ptr, w_ptr_n;
  logic [tag_width_p-1:0] w_idx, w_rr_id;
  logic                   w_rr_found;

  function automatic logic [tag_width_p-1:0] wrap_add(input logic [tag_width_p-1:0] base,
                                                       input int unsigned off);
    int unsigned s;
    s = int'(base) + off;
    return tag_width_p'(s % num_req_p);
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lock_v  <= 1'b0;
      r_lock_id <= '0;
      r_ptr     <= '0;
    end else begin
      r_lock_v  <= w_lock_v_n;
      r_lock_id <= w_lock_id_n;
      r_ptr     <= w_ptr_n;
    end
  end

  always_comb begin
    w_lock_v_n  = r_lock_v;
    w_lock_id_n = r_lock_id;
    w_ptr_n     = r_ptr;
    if (yumi_i) begin
      w_lock_v_n = 1'b0;
      w_ptr_n    = wrap_add(grant_id_o, 1);
    end else if (grant_v_o && !r_lock_v) begin
      w_lock_v_n  = 1'b1;
      w_lock_id_n = grant_id_o;
    end
  end

  always_comb begin
    w_idx      = r_ptr;
    w_rr_id    = r_ptr;
    w_rr_found = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      w_idx = wrap_add(r_ptr, i);
      if (!w_rr_found && reqs_i[w_idx]) begin
        w_rr_found = 1'b1;
        w_rr_id    = w_idx;
      end
    end
    if (r_lock_v) begin
      grant_id_o = r_lock_id;
      grant_v_o  = reqs_i[r_lock_id];
    end else begin
      grant_id_o = w_rr_id;
      grant_v_o  = en_i & w_rr_found;
    end
  end

endmodule

// File: rtl/bp_io_link_arbiter.sv
// Shares one uncached I/O link among several command sources; responses are
// routed back in issue order through a requester-tag FIFO.
module bp_io_link_arbiter
  import bp_io_link_arbiter_pkg::*;
#(
  parameter  int unsigned msg_width_p       = BP_IO_MSG_WIDTH,
  parameter  int unsigned num_req_p         = 3,
  parameter  int unsigned max_outstanding_p = 4,
  localparam int unsigned tag_width_lp      = safe_clog2(num_req_p),
  localparam int unsigned cnt_width_lp      = safe_clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [num_req_p*msg_width_p-1:0] io_cmd_i,
  input  logic [num_req_p-1:0]             io_cmd_v_i,
  output logic [num_req_p-1:0]             io_cmd_yumi_o,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_yumi_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_ready_o,
  output logic [msg_width_p-1:0]           io_resp_o,
  output logic [num_req_p-1:0]             io_resp_v_o,
  input  logic [num_req_p-1:0]             io_resp_ready_i,
  output logic [cnt_width_lp-1:0]          outstanding_o,
  output logic                             err_o
);

  localparam int unsigned ptr_width_lp = safe_clog2(max_outstanding_p);

  logic [tag_width_lp-1:0] r_tag_mem [max_outstanding_p];
  logic [ptr_width_lp-1:0] r_rd_ptr, r_wr_ptr;
  logic [cnt_width_lp-1:0] r_outstanding;
  logic                    r_err;

  logic [tag_width_lp-1:0] w_grant_id, w_head;
  logic                    w_grant_v, w_can_issue, w_issue, w_pop, w_fifo_v;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  // Registered count only: a same-cycle pop never frees a slot for issue.
  assign w_can_issue = (r_outstanding < cnt_width_lp'(max_outstanding_p));

  bp_io_link_rr_lock_arb #(
    .num_req_p   (num_req_p),
    .tag_width_p (tag_width_lp)
  ) u_arb (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .reqs_i     (io_cmd_v_i),
    .en_i       (w_can_issue),
    .yumi_i     (w_issue),
    .grant_id_o (w_grant_id),
    .grant_v_o  (w_grant_v)
  );

  assign io_cmd_v_o = w_grant_v;
  assign w_issue    = io_cmd_yumi_i & w_grant_v;

  always_comb begin
    io_cmd_o      = io_cmd_i[msg_width_p-1:0];
    io_cmd_yumi_o = '0;
    for (int k = 0; k < num_req_p; k++) begin
      if (w_grant_id == tag_width_lp'(k)) io_cmd_o = io_cmd_i[k*msg_width_p +: msg_width_p];
    end
    if (w_issue) io_cmd_yumi_o[w_grant_id] = 1'b1;
  end

  assign w_fifo_v        = (r_outstanding != '0);
  assign w_head          = r_tag_mem[r_rd_ptr];
  assign io_resp_ready_o = w_fifo_v & io_resp_ready_i[w_head];
  assign io_resp_o       = io_resp_i;
  assign w_pop           = io_resp_v_i & io_resp_ready_o;

  always_comb begin
    io_resp_v_o = '0;
    if (io_resp_v_i && w_fifo_v) io_resp_v_o[w_head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (w_issue) r_tag_mem[r_wr_ptr] <= w_grant_id;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      if (w_issue) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)   r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_issue, w_pop})
        2'b10:   r_outstanding <= r_outstanding + cnt_width_lp'(1);
        2'b01:   r_outstanding <= r_outstanding - cnt_width_lp'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (io_resp_v_i && !w_fifo_v) r_err <= 1'b1;
    end
  end

  assign outstanding_o = r_outstanding;
  assign err_o         = r_err;

endmodule

// File: tb/tb_bp_io_link_arbiter.sv
// Directed bench for bp_io_link_arbiter with scoreboarded issue and response checks.
module tb_bp_io_link_arbiter;

  localparam int W  = 16;
  localparam int N  = 3;
  localparam int CW = 3;

  logic           clk = 1'b0;
  logic           reset_i;
  logic [N*W-1:0] io_cmd_i;
  logic [N-1:0]   io_cmd_v_i;
  logic [N-1:0]   io_cmd_yumi_o;
  logic [W-1:0]   io_cmd_o;
  logic           io_cmd_v_o;
  logic           io_cmd_yumi_i;
  logic [W-1:0]   io_resp_i;
  logic           io_resp_v_i;
  logic           io_resp_ready_o;
  logic [W-1:0]   io_resp_o;
  logic [N-1:0]   io_resp_v_o;
  logic [N-1:0]   io_resp_ready_i;
  logic [CW-1:0]  outstanding_o;
  logic           err_o;
  logic           accept;

  always #5 clk = ~clk;

  // Link model: consumes whenever it is willing and a command is offered.
  assign io_cmd_yumi_i = accept & io_cmd_v_o;

  bp_io_link_arbiter #(.msg_width_p(W), .num_req_p(N), .max_outstanding_p(4)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .io_cmd_i        (io_cmd_i),
    .io_cmd_v_i      (io_cmd_v_i),
    .io_cmd_yumi_o   (io_cmd_yumi_o),
    .io_cmd_o        (io_cmd_o),
    .io_cmd_v_o      (io_cmd_v_o),
    .io_cmd_yumi_i   (io_cmd_yumi_i),
    .io_resp_i       (io_resp_i),
    .io_resp_v_i     (io_resp_v_i),
    .io_resp_ready_o (io_resp_ready_o),
    .io_resp_o       (io_resp_o),
    .io_resp_v_o     (io_resp_v_o),
    .io_resp_ready_i (io_resp_ready_i),
    .outstanding_o   (outstanding_o),
    .err_o           (err_o)
  );

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] data;
  } exp_t;

  exp_t q_issue[$];
  exp_t q_resp[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   ord4[4] = '{1, 2, 0, 1};
  int   ord3[3] = '{1, 2, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pay(input int k);
    return 16'hA5A0 + 16'(k);
  endfunction

  task automatic push_issue(input int k);
    exp_t e;
    e.mask    = '0;
    e.mask[k] = 1'b1;
    e.data    = pay(k);
    q_issue.push_back(e);
  endtask

  task automatic push_resp(input int k, input logic [W-1:0] d);
    exp_t e;
    e.mask    = '0;
    e.mask[k] = 1'b1;
    e.data    = d;
    q_resp.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i         = 1'b1;
    io_cmd_v_i      = '0;
    accept          = 1'b0;
    io_resp_v_i     = 1'b0;
    io_resp_ready_i = 3'b111;
    step();
    step();
    reset_i = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (io_cmd_yumi_o != '0) begin
      if (q_issue.size() == 0) check("issue_unexpected", 32'(io_cmd_yumi_o), 32'd0);
      else begin
        e = q_issue.pop_front();
        check("issue_yumi", 32'(io_cmd_yumi_o), 32'(e.mask));
        check("issue_cmd", 32'(io_cmd_o), 32'(e.data));
      end
    end
    if (io_resp_v_i && io_resp_ready_o) begin
      if (q_resp.size() == 0) check("resp_unexpected", 32'(io_resp_v_o), 32'd0);
      else begin
        e = q_resp.pop_front();
        check("resp_v", 32'(io_resp_v_o), 32'(e.mask));
        check("resp_data", 32'(io_resp_o), 32'(e.data));
      end
    end
  end

  initial begin
    reset_i         = 1'b1;
    io_cmd_i        = {pay(2), pay(1), pay(0)};
    io_cmd_v_i      = '0;
    accept          = 1'b0;
    io_resp_i       = '0;
    io_resp_v_i     = 1'b0;
    io_resp_ready_i = 3'b111;
    step();
    step();
    neg();
    check("rst_out", 32'(outstanding_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_cmd_v", 32'(io_cmd_v_o), 0);
    check("rst_cmd_yumi", 32'(io_cmd_yumi_o), 0);
    check("rst_resp_ready", 32'(io_resp_ready_o), 0);
    check("rst_resp_v", 32'(io_resp_v_o), 0);
    step();
    reset_i = 1'b0;

    // single issue and return
    io_cmd_v_i = 3'b001; accept = 1'b1; push_issue(0);
    neg(); check("t1_out_pre", 32'(outstanding_o), 0);
    step(); io_cmd_v_i = '0; accept = 1'b0;
    neg(); check("t1_out", 32'(outstanding_o), 1);
    step(); io_resp_v_i = 1'b1; io_resp_i = 16'h1111; push_resp(0, 16'h1111);
    neg();
    step(); io_resp_v_i = 1'b0;
    neg(); check("t1_out_after", 32'(outstanding_o), 0);

    // round-robin under full load, stall at the limit
    step(); do_reset();
    io_cmd_v_i = 3'b111; accept = 1'b1;
    push_issue(0); push_issue(1); push_issue(2); push_issue(0);
    for (int c = 0; c < 6; c++) begin
      neg();
      check("t2_cmd_v", 32'(io_cmd_v_o), (c < 4) ? 1 : 0);
      check("t2_out", 32'(outstanding_o), (c < 4) ? c : 4);
      step();
    end
    // pop at the limit does not free a slot in the same cycle
    io_resp_v_i = 1'b1; io_resp_i = 16'h2222; push_resp(0, 16'h2222);
    neg();
    check("t5_pop_cmd_v", 32'(io_cmd_v_o), 0);
    check("t5_pop_out", 32'(outstanding_o), 4);
    step(); io_resp_v_i = 1'b0; push_issue(1);
    neg();
    check("t5_cmd_v", 32'(io_cmd_v_o), 1);
    check("t5_out", 32'(outstanding_o), 3);
    step(); io_cmd_v_i = '0; accept = 1'b0;
    neg(); check("t5_out_refill", 32'(outstanding_o), 4);
    for (int i = 0; i < 4; i++) begin
      step(); io_resp_v_i = 1'b1; io_resp_i = 16'h3000 + 16'(i); push_resp(ord4[i], 16'h3000 + 16'(i));
      neg();
    end
    step(); io_resp_v_i = 1'b0;
    neg(); check("t2_drain_out", 32'(outstanding_o), 0);

    // locked grant while the link stalls
    step(); do_reset();
    io_cmd_v_i = 3'b110; accept = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) io_cmd_v_i = 3'b111;
      neg();
      check("t3_cmd_v", 32'(io_cmd_v_o), 1);
      check("t3_cmd", 32'(io_cmd_o), 32'(pay(1)));
      check("t3_yumi", 32'(io_cmd_yumi_o), 0);
      step();
    end
    accept = 1'b1; push_issue(1);
    neg();
    step(); io_cmd_v_i = 3'b101; push_issue(2);
    neg();
    step(); io_cmd_v_i = 3'b001; push_issue(0);
    neg();
    step(); io_cmd_v_i = '0; accept = 1'b0;
    neg(); check("t3_out", 32'(outstanding_o), 3);
    for (int i = 0; i < 3; i++) begin
      step(); io_resp_v_i = 1'b1; io_resp_i = 16'h3100 + 16'(i); push_resp(ord3[i], 16'h3100 + 16'(i));
      neg();
    end

    // issue order 2,0,2 and head-of-line hold on a busy source
    step(); io_resp_v_i = 1'b0; io_cmd_v_i = 3'b101; accept = 1'b1;
    push_issue(2); push_issue(0); push_issue(2);
    neg(); step(); neg(); step(); neg();
    step(); io_cmd_v_i = '0; accept = 1'b0;
    neg(); check("t4_out", 32'(outstanding_o), 3);
    step(); io_resp_v_i = 1'b1; io_resp_ready_i = 3'b110; io_resp_i = 16'h4000; push_resp(2, 16'h4000);
    neg();
    step(); io_resp_i = 16'h4001;
    neg();
    check("t4_hold_ready", 32'(io_resp_ready_o), 0);
    check("t4_hold_v", 32'(io_resp_v_o), 32'b001);
    check("t4_hold_out", 32'(outstanding_o), 2);
    step(); io_resp_ready_i = 3'b111; push_resp(0, 16'h4001);
    neg();
    step(); io_resp_i = 16'h4002; push_resp(2, 16'h4002);
    neg();
    step(); io_resp_v_i = 1'b0;
    neg(); check("t4_out_after", 32'(outstanding_o), 0);

    // unexpected response, then reset with commands in flight
    step(); io_resp_v_i = 1'b1; io_resp_i = 16'h5555;
    neg();
    check("t6_ready", 32'(io_resp_ready_o), 0);
    check("t6_resp_v", 32'(io_resp_v_o), 0);
    step(); io_resp_v_i = 1'b0;
    neg(); check("t6_err", 32'(err_o), 1);
    step();
    neg();
    check("t6_err_hold", 32'(err_o), 1);
    check("t6_out_zero", 32'(outstanding_o), 0);
    step(); io_cmd_v_i = 3'b011; accept = 1'b1; push_issue(0); push_issue(1);
    neg(); step(); neg();
    step(); io_cmd_v_i = '0; accept = 1'b0;
    neg();
    check("t6_out_two", 32'(outstanding_o), 2);
    check("t6_err_still", 32'(err_o), 1);
    step(); reset_i = 1'b1;
    neg();
    step(); reset_i = 1'b0;
    neg();
    check("t6_rst_out", 32'(outstanding_o), 0);
    check("t6_rst_err", 32'(err_o), 0);
    step(); io_cmd_v_i = 3'b111; accept = 1'b1; push_issue(0);
    neg();
    step(); io_cmd_v_i = '0; accept = 1'b0;
    neg();

    check("issue_queue_empty", 32'(q_issue.size()), 0);
    check("resp_queue_empty", 32'(q_resp.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
